div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 Parameter: none; datapath width fixed at 32 bits (RV32M).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 op1  input  32  dividend (rs1), sampled only on accept.
REQ-005 op2  input  32  divisor (rs2), sampled only on accept.
REQ-006 func3  input  3  op select: DIV=100, DIVU=101, REM=110, REMU=111.
REQ-007 div_en  input  1  start request; accepted only when the state is IDLE and func3[2]=1.
REQ-008 reg_waddr_i  input  5  destination register tag, latched on accept.
REQ-009 busy_o  output  1  high while an operation is in flight (START, CALC, END).
REQ-010 ready_o  output  1  one-cycle pulse; result_o and reg_waddr_o are valid this cycle.
REQ-011 result_o  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-012 reg_waddr_o  output  5  latched destination tag, held until the next accept.

Function
REQ-013 FSM states SHALL be: IDLE, START, CALC, END.
REQ-014 IDLE SHALL go to START on accept (div_en=1, func3[2]=1) and latch op1, op2, func3 and reg_waddr_i; otherwise it SHALL stay in IDLE.
REQ-015 div_en SHALL be ignored when func3[2]=0, in any state other than IDLE, and in the END cycle.
REQ-016 Input changes after accept SHALL NOT affect the in-flight result.
REQ-017 START, special cases: if divisor=0, go to END with quotient=0xFFFFFFFF and remainder=dividend (signed and unsigned).
REQ-018 START, signed overflow: DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF SHALL go to END with quotient=0x80000000 and remainder=0.
REQ-019 START, otherwise: signed ops SHALL take the magnitudes of both operands; unsigned ops SHALL use the raw operands; the FSM then goes to CALC with the iteration counter at 0.
REQ-020 CALC SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, producing one quotient bit per cycle, MSB first.
REQ-021 After the 32nd step, the FSM SHALL go to END.
REQ-022 Sign fix-up in END, signed ops: quotient negated iff op1[31] XOR op2[31]; remainder negated iff op1[31]; two's-complement, modulo 2^32.
REQ-023 END SHALL assert ready_o for exactly one cycle, drive result_o, and return to IDLE.
REQ-024 Latency, with the accept edge at T: normal ops give ready_o at cycle T+34; special cases give ready_o at T+2.
REQ-025 busy_o SHALL be 1 from cycle T+1 through the END cycle inclusive, and 0 in IDLE.
REQ-026 result_o SHALL hold its last value after END until the next END; it SHALL be 0 after reset.
REQ-027 The remainder SHALL satisfy dividend = quotient*divisor + remainder, with |remainder| < |divisor|.

Reset
REQ-028 When rst=1 at a clock edge: state=IDLE, busy_o=0, ready_o=0, result_o=0, reg_waddr_o=0, and all internal registers cleared.
REQ-029 Reset mid-operation SHALL abort the operation with no ready_o pulse; the block SHALL accept again from the first cycle after rst deasserts.
REQ-030 div_en in the same cycle as rst=1 SHALL be ignored.

Structure
REQ-031 The func3 encodings INST_DIV, INST_DIVU, INST_REM and INST_REMU SHALL live in the shared instruction-defines file alongside the MUL encodings.
REQ-032 The FSM state encodings SHALL be local to the module.
REQ-033 The block SHALL be a single module with no sub-module: 32-bit subtractor, 6-bit iteration counter, dividend/quotient/remainder shift registers.
REQ-034 The block SHALL use no combinational feedback and no latches; every register SHALL be clocked on clk.

Verification
REQ-035 DIVU 100/7, accept at T -> busy_o=1 T+1..T+34; ready_o=1 at T+34; result_o=14.
REQ-036 DIV 0xFFFFFF9C/7 (-100/7) -> result_o=0xFFFFFFF2 (-14); REM with the same operands -> result_o=0xFFFFFFFE (-2).
REQ-037 DIVU 5/0 -> result_o=0xFFFFFFFF at T+2; REMU 5/0 -> result_o=5 at T+2.
REQ-038 DIV 0x80000000/0xFFFFFFFF -> result_o=0x80000000 at T+2; REM with the same operands -> result_o=0.
REQ-039 DIVU 100/7 accepted, then op1/op2 changed and div_en pulsed at T+5 -> result_o=14 at T+34; no second operation starts.
REQ-040 rst=1 at T+10 mid-CALC -> busy_o=0 and ready_o stays 0 from T+11; a new DIVU 9/3 accepted after reset -> result_o=3.

Source files
------------

// File: rtl/div_pkg.sv
// Shared RV32M instruction defines and small arithmetic helpers.
// Holds the func3 encodings for the MUL and DIV families so decode
// logic and execution units agree on one set of constants.
package div_pkg;

  // MUL family (func3[2] = 0)
  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;

  // DIV family (func3[2] = 1)
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  // Two's-complement negation, modulo 2^32.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of a signed 32-bit value; 0x80000000 maps to itself,
  // which is still the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/div.sv
// RV32M divider: DIV, DIVU, REM, REMU using a restoring shift-subtract
// loop, one quotient bit per cycle (32 iterations).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op1, op2        dividend / divisor, sampled on accept
//   func3           operation select (func3[2] must be 1 to accept)
//   div_en          start request, honoured only in IDLE
//   reg_waddr_i     destination tag, latched on accept
//   busy_o          high while an operation is in flight
//   ready_o         one-cycle pulse with valid result_o / reg_waddr_o
//   result_o        quotient or remainder, held until the next result
//   reg_waddr_o     latched destination tag
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [2:0]  func3,
  input  logic        div_en,
  input  logic [4:0]  reg_waddr_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic [4:0]  reg_waddr_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

  state_t      state_q, state_d;
  logic [31:0] op1_q, op2_q;
  logic [2:0]  func3_q;
  logic [4:0]  waddr_q;
  logic [31:0] dividend_q, divisor_q, quot_q, rem_q, result_q;
  logic [5:0]  cnt_q;
  logic        special_q;

  logic        accept;
  logic        signed_op, rem_op;
  logic        div_zero, overflow;
  logic [32:0] shifted, diff;
  logic        qbit;
  logic [31:0] quot_fix, rem_fix, final_result;

  assign accept    = (state_q == S_IDLE) && div_en && func3[2];
  assign signed_op = (func3_q == INST_DIV) || (func3_q == INST_REM);
  assign rem_op    = (func3_q == INST_REM) || (func3_q == INST_REMU);
  assign div_zero  = (op2_q == 32'd0);
  assign overflow  = signed_op && (op1_q == 32'h8000_0000) && (op2_q == 32'hFFFF_FFFF);

  // One restoring step: bring down the next dividend bit, try to subtract.
  // The 33rd bit is needed because the shifted remainder can exceed 2^32-1.
  assign shifted = {rem_q, dividend_q[31]};
  assign diff    = shifted - {1'b0, divisor_q};
  assign qbit    = ~diff[32];

  // Special-case results are already final, so the sign fix-up skips them.
  assign quot_fix = (signed_op && !special_q && (op1_q[31] ^ op2_q[31])) ? neg32(quot_q) : quot_q;
  assign rem_fix  = (signed_op && !special_q && op1_q[31]) ? neg32(rem_q) : rem_q;
  assign final_result = rem_op ? rem_fix : quot_fix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: state_d = (div_zero || overflow) ? S_END : S_CALC;
      S_CALC:  if (cnt_q == 6'd31) state_d = S_END;
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    ready_o  = (state_q == S_END);
    result_o = result_q;
    if (state_q == S_END) result_o = final_result;
  end

  assign reg_waddr_o = waddr_q;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q      <= '0;
      op2_q      <= '0;
      func3_q    <= '0;
      waddr_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      special_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op1_q   <= op1;
            op2_q   <= op2;
            func3_q <= func3;
            waddr_q <= reg_waddr_i;
          end
        end
        S_START: begin
          cnt_q <= '0;
          if (div_zero) begin
            quot_q    <= 32'hFFFF_FFFF;
            rem_q     <= op1_q;
            special_q <= 1'b1;
          end else if (overflow) begin
            quot_q    <= 32'h8000_0000;
            rem_q     <= 32'd0;
            special_q <= 1'b1;
          end else begin
            dividend_q <= signed_op ? abs32(op1_q) : op1_q;
            divisor_q  <= signed_op ? abs32(op2_q) : op2_q;
            quot_q     <= '0;
            rem_q      <= '0;
            special_q  <= 1'b0;
          end
        end
        S_CALC: begin
          dividend_q <= {dividend_q[30:0], 1'b0};
          rem_q      <= qbit ? diff[31:0] : shifted[31:0];
          quot_q     <= {quot_q[30:0], qbit};
          cnt_q      <= cnt_q + 6'd1;
        end
        S_END: result_q <= final_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: a cycle-level behavioural model computes
// results with plain integer arithmetic and a latency countdown; a monitor
// compares every DUT output each cycle. Directed scenarios pin literal
// results and latencies, then a randomized phase stresses the block.
module tb_div;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [2:0]  func3 = '0;
  logic        div_en = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic        busy_o, ready_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int n_tests = 0;
  int n_fail  = 0;

  div dut (
    .clk(clk), .rst(rst), .op1(op1), .op2(op2), .func3(func3),
    .div_en(div_en), .reg_waddr_i(reg_waddr_i), .busy_o(busy_o),
    .ready_o(ready_o), .result_o(result_o), .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    bit sgn;
    sgn = (f3[0] == 1'b0);
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (sgn) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 2;
    if (f3[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // m_cnt: cycles left in flight including the current one (1 = ready cycle)
  int          m_cnt = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_last = '0;
  logic [4:0]  m_waddr = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_last = '0; m_waddr = '0; m_valid = 1'b1;
    end else if (m_cnt > 0) begin
      if (m_cnt == 1) m_last = m_pend;
      m_cnt--;
    end else if (div_en && func3[2]) begin
      m_pend  = ref_result(func3, op1, op2);
      m_cnt   = ref_latency(func3, op1, op2);
      m_waddr = reg_waddr_i;
      $display("[TB] accept f3=%b op1=%h op2=%h tag=%0d expect=%h lat=%0d",
               func3, op1, op2, reg_waddr_i, m_pend, m_cnt);
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy_o", 32'(busy_o), 32'(m_cnt != 0));
      check("ready_o", 32'(ready_o), 32'(m_cnt == 1));
      check("result_o", result_o, (m_cnt == 1) ? m_pend : m_last);
      check("reg_waddr_o", 32'(reg_waddr_o), 32'(m_waddr));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (m_cnt != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", 32'(m_cnt), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input int exp_lat);
    int t;
    wait_idle();
    op1 = a; op2 = b; func3 = f3; reg_waddr_i = tag; div_en = 1'b1;
    @(negedge clk);
    div_en = 1'b0;
    t = 1;
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({name, "_lat"}, 32'(t), 32'(exp_lat));
    check({name, "_res"}, result_o, exp_res);
    check({name, "_tag"}, 32'(reg_waddr_o), 32'(tag));
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int t;
    int ready_seen;

    // Pin the reference model with hand-computed values
    check("model_divu", ref_result(INST_DIVU, 32'd100, 32'd7), 32'd14);
    check("model_div", ref_result(INST_DIV, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);
    check("model_rem", ref_result(INST_REM, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
    check("model_divu0", ref_result(INST_DIVU, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("model_remu0", ref_result(INST_REMU, 32'd5, 32'd0), 32'd5);
    check("model_ovf", ref_result(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_tag", 32'(reg_waddr_o), 32'd0);
    rst = 1'b0;

    // Directed results and latencies
    run_op("divu_100_7", INST_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34);
    run_op("div_m100_7", INST_DIV, 32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFF2, 34);
    run_op("rem_m100_7", INST_REM, 32'hFFFF_FF9C, 32'd7, 5'd5, 32'hFFFF_FFFE, 34);
    run_op("divu_5_0", INST_DIVU, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 2);
    run_op("remu_5_0", INST_REMU, 32'd5, 32'd0, 5'd7, 32'd5, 2);
    run_op("div_ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 2);
    run_op("rem_ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 2);
    run_op("div_m7_0", INST_DIV, 32'hFFFF_FFF9, 32'd0, 5'd10, 32'hFFFF_FFFF, 2);

    // Inputs changed and div_en pulsed while busy: no effect
    wait_idle();
    op1 = 32'd100; op2 = 32'd7; func3 = INST_DIVU; reg_waddr_i = 5'd11; div_en = 1'b1;
    @(negedge clk);
    div_en = 1'b0;
    t = 1;
    repeat (3) begin @(negedge clk); t++; end
    op1 = 32'd1000; op2 = 32'd3; func3 = INST_DIV; reg_waddr_i = 5'd12; div_en = 1'b1;
    @(negedge clk);
    t++;
    div_en = 1'b0;
    while (!ready_o && t < 100) begin @(negedge clk); t++; end
    check("ignore_lat", 32'(t), 32'd34);
    check("ignore_res", result_o, 32'd14);
    check("ignore_tag", 32'(reg_waddr_o), 32'd11);
    @(negedge clk);
    check("ignore_no_second", 32'(busy_o), 32'd0);

    // Reset mid-CALC aborts with no ready pulse
    wait_idle();
    op1 = 32'd100; op2 = 32'd7; func3 = INST_DIVU; reg_waddr_i = 5'd13; div_en = 1'b1;
    @(negedge clk);
    div_en = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_result", result_o, 32'd0);
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) ready_seen++;
    end
    check("abort_no_ready", 32'(ready_seen), 32'd0);
    run_op("divu_9_3", INST_DIVU, 32'd9, 32'd3, 5'd14, 32'd3, 34);

    // div_en together with rst is ignored
    wait_idle();
    rst = 1'b1; div_en = 1'b1; func3 = INST_DIVU; op1 = 32'd50; op2 = 32'd5;
    @(negedge clk);
    rst = 1'b0; div_en = 1'b0;
    check("rst_en_busy", 32'(busy_o), 32'd0);

    // div_en with func3[2]=0 is ignored
    func3 = INST_MUL; div_en = 1'b1;
    @(negedge clk);
    div_en = 1'b0;
    check("mul_ignored", 32'(busy_o), 32'd0);

    // Randomized phase, checked every cycle by the monitor
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 399) == 0);
      div_en      = ($urandom_range(0, 3) == 0);
      func3       = 3'($urandom_range(0, 7));
      op1         = rand_op();
      op2         = rand_op();
      reg_waddr_i = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    rst = 1'b0; div_en = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
